// File: rtl/usb_reg_host.sv
// Register-bus host: turns byte-burst commands into timed cen/rdn/wrn cycles
// against a parallel target, with a fixed address for the whole burst.
module usb_reg_host #(
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pSETUP        = 1,
  parameter int unsigned pSTROBE       = 3,
  parameter int unsigned pHOLD         = 2
) (
  input  logic                     cwusb_clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     contention,
  output logic [7:0]               usb_addr,
  output logic [7:0]               usb_dout,
  input  logic [7:0]               usb_din,
  output logic                     usb_cen,
  output logic                     usb_rdn,
  output logic                     usb_wrn,
  output logic                     usb_drive,
  input  logic                     usb_isout
);

  localparam int unsigned PH_W  = 4;
  localparam int unsigned CNT_W = pBYTECNT_SIZE;
  localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(pSETUP - 1);
  localparam logic [PH_W-1:0] STROBE_LAST = PH_W'(pSTROBE - 1);
  localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(pHOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              cont_q, cont_d;
  logic              cen_q, cen_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              drive_q, drive_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wr_ready_q, wr_ready_d;

  // Next-state, datapath and output decode; bus outputs are decoded from
  // state_d so every pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    cont_d     = cont_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          cnt_d   = cmd_len;
          cont_d  = 1'b0;
          phase_d = '0;
          state_d = cmd_write ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        if (wr_valid) begin
          dout_d  = wr_data;
          phase_d = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = '0;
          state_d = S_STROBE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_STROBE: begin
        if (phase_q == STROBE_LAST) begin
          phase_d = '0;
          state_d = S_HOLD;
          if (!write_q) begin
            rd_data_d  = usb_din;
            rd_valid_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = '0;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = write_q ? S_WDATA : S_SETUP;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    // Sticky until the next accepted command (drive is low in IDLE).
    if (drive_q && usb_isout) begin
      cont_d = 1'b1;
    end

    cen_d      = (state_d == S_IDLE);
    rdn_d      = !((state_d == S_STROBE) && !write_d);
    wrn_d      = !((state_d == S_STROBE) && write_d);
    drive_d    = write_d && ((state_d == S_SETUP) || (state_d == S_STROBE) ||
                             (state_d == S_HOLD));
    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    wr_ready_d = (state_d == S_WDATA);
  end

  always_ff @(posedge cwusb_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cont_q     <= 1'b0;
      cen_q      <= 1'b1;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      drive_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      cont_q     <= cont_d;
      cen_q      <= cen_d;
      rdn_q      <= rdn_d;
      wrn_q      <= wrn_d;
      drive_q    <= drive_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign wr_ready   = wr_ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign contention = cont_q;
  assign usb_addr   = addr_q;
  assign usb_dout   = dout_q;
  assign usb_cen    = cen_q;
  assign usb_rdn    = rdn_q;
  assign usb_wrn    = wrn_q;
  assign usb_drive  = drive_q;

endmodule

// File: tb/tb_usb_reg_host.sv
// Directed bench for usb_reg_host with default timing (setup 1, strobe 3, hold 2).
module tb_usb_reg_host;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [6:0] cmd_len = 7'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy, done, contention;
  logic [7:0] usb_addr, usb_dout;
  logic [7:0] usb_din = 8'h00;
  logic       usb_cen, usb_rdn, usb_wrn, usb_drive;
  logic       usb_isout = 1'b0;

  int checks = 0;
  int failures = 0;

  usb_reg_host dut (
    .cwusb_clk (clk),
    .reset     (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .contention(contention),
    .usb_addr  (usb_addr),
    .usb_dout  (usb_dout),
    .usb_din   (usb_din),
    .usb_cen   (usb_cen),
    .usb_rdn   (usb_rdn),
    .usb_wrn   (usb_wrn),
    .usb_drive (usb_drive),
    .usb_isout (usb_isout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [6:0] l);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (usb_cen !== 1'b1) begin failures++; $display("FAIL reset_cen got=%b exp=1", usb_cen); end
    checks++; if (usb_rdn !== 1'b1) begin failures++; $display("FAIL reset_rdn got=%b exp=1", usb_rdn); end
    checks++; if (usb_wrn !== 1'b1) begin failures++; $display("FAIL reset_wrn got=%b exp=1", usb_wrn); end
    checks++; if (usb_drive !== 1'b0) begin failures++; $display("FAIL reset_drive got=%b exp=0", usb_drive); end
    checks++; if (usb_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", usb_addr); end
    checks++; if (usb_dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", usb_dout); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (contention !== 1'b0) begin failures++; $display("FAIL reset_contention got=%b exp=0", contention); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_single();
    int cen_n = 0, wrn_n = 0, drv_n = 0, rdy_n = 0, done_n = 0, done_at = -1;
    int bad_dout = 0, bad_addr = 0, bad_rdn = 0;
    wr_data = 8'hA5;
    wr_valid = 1'b1;
    send_cmd(1'b1, 8'h12, 7'd0);
    for (int i = 1; i <= 15; i++) begin
      if (!usb_cen) begin cen_n++; if (usb_addr !== 8'h12) bad_addr++; end
      if (!usb_wrn) wrn_n++;
      if (!usb_rdn) bad_rdn++;
      if (usb_drive) begin drv_n++; if (usb_dout !== 8'hA5) bad_dout++; end
      if (wr_ready) rdy_n++;
      if (done) begin done_n++; if (done_at < 0) done_at = i; end
      step();
    end
    wr_valid = 1'b0;
    checks++; if (cen_n != 7) begin failures++; $display("FAIL wr1_cen_cycles got=%0d exp=7", cen_n); end
    checks++; if (wrn_n != 3) begin failures++; $display("FAIL wr1_wrn_cycles got=%0d exp=3", wrn_n); end
    checks++; if (drv_n != 6) begin failures++; $display("FAIL wr1_drive_cycles got=%0d exp=6", drv_n); end
    checks++; if (bad_dout != 0) begin failures++; $display("FAIL wr1_dout_bad_cycles got=%0d exp=0", bad_dout); end
    checks++; if (bad_addr != 0) begin failures++; $display("FAIL wr1_addr_bad_cycles got=%0d exp=0", bad_addr); end
    checks++; if (bad_rdn != 0) begin failures++; $display("FAIL wr1_rdn_low_cycles got=%0d exp=0", bad_rdn); end
    checks++; if (rdy_n != 1) begin failures++; $display("FAIL wr1_wr_ready_cycles got=%0d exp=1", rdy_n); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL wr1_done_pulses got=%0d exp=1", done_n); end
    checks++; if (done_at != 8) begin failures++; $display("FAIL wr1_done_cycle got=%0d exp=8", done_at); end
  endtask

  task automatic test_read_burst();
    int n = 0, cen_n = 0, rdn_n = 0, wrn_n = 0, drv_n = 0, done_n = 0;
    int bad_addr = 0, bad_data = 0;
    send_cmd(1'b0, 8'h40, 7'd3);
    for (int i = 1; i <= 40; i++) begin
      usb_din = 8'(16 + n);
      if (!usb_cen) begin cen_n++; if (usb_addr !== 8'h40) bad_addr++; end
      if (!usb_rdn) rdn_n++;
      if (!usb_wrn) wrn_n++;
      if (usb_drive) drv_n++;
      if (done) done_n++;
      if (rd_valid) begin
        if (rd_data !== 8'(16 + n)) begin
          bad_data++;
          $display("FAIL rd_byte%0d got=%h exp=%h", n, rd_data, 8'(16 + n));
        end
        n++;
      end
      step();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL rd_valid_pulses got=%0d exp=4", n); end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL rd_data_bad got=%0d exp=0", bad_data); end
    checks++; if (cen_n != 24) begin failures++; $display("FAIL rd_cen_cycles got=%0d exp=24", cen_n); end
    checks++; if (rdn_n != 12) begin failures++; $display("FAIL rd_rdn_cycles got=%0d exp=12", rdn_n); end
    checks++; if (wrn_n != 0) begin failures++; $display("FAIL rd_wrn_cycles got=%0d exp=0", wrn_n); end
    checks++; if (drv_n != 0) begin failures++; $display("FAIL rd_drive_cycles got=%0d exp=0", drv_n); end
    checks++; if (bad_addr != 0) begin failures++; $display("FAIL rd_addr_bad got=%0d exp=0", bad_addr); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL rd_done_pulses got=%0d exp=1", done_n); end
  endtask

  task automatic test_write_stall();
    int sent = 0, stall_cnt = 0, stall_bad = 0, cen_n = 0, done_n = 0, k = 0;
    logic pending = 1'b0;
    logic prev_wrn = 1'b1;
    logic [7:0] got [2];
    got[0] = 8'h00;
    got[1] = 8'h00;
    wr_data = 8'h3C;
    wr_valid = 1'b1;
    send_cmd(1'b1, 8'h07, 7'd1);
    for (int i = 1; i <= 40; i++) begin
      if (pending) begin sent++; pending = 1'b0; wr_valid = 1'b0; end
      if (wr_ready && !wr_valid && sent == 1) begin
        if (usb_cen || !usb_wrn) stall_bad++;
        if (stall_cnt == 5) begin wr_valid = 1'b1; wr_data = 8'h5A; end
        else stall_cnt++;
      end
      if (wr_ready && wr_valid) pending = 1'b1;
      if (!usb_cen) cen_n++;
      if (done) done_n++;
      if (!usb_wrn && prev_wrn) begin
        if (k < 2) got[k] = usb_dout;
        k++;
      end
      prev_wrn = usb_wrn;
      step();
    end
    wr_valid = 1'b0;
    checks++; if (k != 2) begin failures++; $display("FAIL stall_strobes got=%0d exp=2", k); end
    checks++; if (got[0] !== 8'h3C) begin failures++; $display("FAIL stall_byte0 got=%h exp=3c", got[0]); end
    checks++; if (got[1] !== 8'h5A) begin failures++; $display("FAIL stall_byte1 got=%h exp=5a", got[1]); end
    checks++; if (stall_cnt != 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_cnt); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_pin_state got=%0d exp=0", stall_bad); end
    checks++; if (cen_n != 19) begin failures++; $display("FAIL stall_cen_cycles got=%0d exp=19", cen_n); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL stall_done_pulses got=%0d exp=1", done_n); end
  endtask

  task automatic test_reset_mid_strobe();
    int wn = 0, rv_n = 0, done_n = 0, bad_addr = 0, bad_data = 0;
    wr_data = 8'h77;
    wr_valid = 1'b1;
    send_cmd(1'b1, 8'h33, 7'd0);
    for (int i = 1; i <= 20; i++) begin
      if (!usb_wrn) wn++;
      if (wn == 2) break;
      step();
    end
    checks++; if (wn != 2) begin failures++; $display("FAIL mid_reach_strobe2 got=%0d exp=2", wn); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({usb_cen, usb_rdn, usb_wrn} !== 3'b111) begin failures++; $display("FAIL mid_rst_strobes got=%b exp=111", {usb_cen, usb_rdn, usb_wrn}); end
    checks++; if (usb_drive !== 1'b0) begin failures++; $display("FAIL mid_rst_drive got=%b exp=0", usb_drive); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_ready_busy got=%b%b exp=10", cmd_ready, busy); end
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    usb_din = 8'h99;
    send_cmd(1'b0, 8'h55, 7'd0);
    for (int i = 1; i <= 12; i++) begin
      if (!usb_cen && usb_addr !== 8'h55) bad_addr++;
      if (rd_valid) begin rv_n++; if (rd_data !== 8'h99) bad_data++; end
      if (done) done_n++;
      step();
    end
    checks++; if (rv_n != 1 || bad_data != 0) begin failures++; $display("FAIL post_rst_read got=%0d/%0d exp=1/0", rv_n, bad_data); end
    checks++; if (bad_addr != 0) begin failures++; $display("FAIL post_rst_addr got=%0d exp=0", bad_addr); end
    checks++; if (done_n != 1) begin failures++; $display("FAIL post_rst_done got=%0d exp=1", done_n); end
  endtask

  task automatic test_contention();
    logic seen_wrn = 1'b0;
    int cont_at_done = -1;
    wr_data = 8'h11;
    wr_valid = 1'b1;
    send_cmd(1'b1, 8'h66, 7'd0);
    checks++; if (contention !== 1'b0) begin failures++; $display("FAIL cont_initial got=%b exp=0", contention); end
    for (int i = 1; i <= 12; i++) begin
      if (!usb_wrn) seen_wrn = 1'b1;
      usb_isout = seen_wrn && usb_wrn && usb_drive;
      if (done) cont_at_done = int'(contention);
      step();
    end
    usb_isout = 1'b0;
    wr_valid = 1'b0;
    step();
    checks++; if (cont_at_done != 1) begin failures++; $display("FAIL cont_at_done got=%0d exp=1", cont_at_done); end
    checks++; if (contention !== 1'b1) begin failures++; $display("FAIL cont_sticky got=%b exp=1", contention); end
    send_cmd(1'b0, 8'h66, 7'd0);
    checks++; if (contention !== 1'b0) begin failures++; $display("FAIL cont_clear_on_accept got=%b exp=0", contention); end
    repeat (10) step();
  endtask

  task automatic test_back_to_back();
    int acc = 0, acc2_at = -1, dn = 0, bad_done = 0;
    usb_din = 8'h42;
    cmd_write = 1'b0;
    cmd_addr = 8'h21;
    cmd_len = 7'd0;
    cmd_valid = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (acc == 2) cmd_valid = 1'b0;
      if (cmd_ready && cmd_valid) begin
        acc++;
        if (acc == 2) begin acc2_at = i; if (!done) bad_done++; end
      end
      if (done) dn++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (acc != 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", acc); end
    checks++; if (acc2_at != 8) begin failures++; $display("FAIL b2b_second_accept_cycle got=%0d exp=8", acc2_at); end
    checks++; if (bad_done != 0) begin failures++; $display("FAIL b2b_accept_on_done got=%0d exp=0", bad_done); end
    checks++; if (dn != 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", dn); end
  endtask

  task automatic test_max_len();
    int rv_n = 0, cen_n = 0;
    logic finished = 1'b0;
    usb_din = 8'hC3;
    send_cmd(1'b0, 8'h7E, 7'h7F);
    for (int i = 1; i <= 1000; i++) begin
      if (!usb_cen) cen_n++;
      if (rd_valid) rv_n++;
      if (done) begin finished = 1'b1; break; end
      step();
    end
    checks++; if (!finished) begin failures++; $display("FAIL max_len_timeout got=0 exp=1"); end
    checks++; if (rv_n != 128) begin failures++; $display("FAIL max_len_bytes got=%0d exp=128", rv_n); end
    checks++; if (cen_n != 768) begin failures++; $display("FAIL max_len_cen_cycles got=%0d exp=768", cen_n); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_write_stall();
    test_reset_mid_strobe();
    test_contention();
    test_back_to_back();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_reg_host.md
USB_REG_HOST -- requirements
Module: usb_reg_host

Interface
REQ-001 Parameter pBYTECNT_SIZE, default 7, width of the burst length field; a burst is 1..2^pBYTECNT_SIZE bytes.
REQ-002 Parameter pSETUP, default 1, cycles address/data are stable before strobe; legal range 1..15.
REQ-003 Parameter pSTROBE, default 3, cycles rdn/wrn are held low; legal range 2..15.
REQ-004 Parameter pHOLD, default 2, cycles after strobe release before next byte or end; legal range 1..15.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 cwusb_clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 cmd_valid, cmd_ready  in/out  1/1  command handshake; transfer on cycle both high.
REQ-009 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_addr  in  8  register address for the whole burst.
REQ-011 cmd_len  in  pBYTECNT_SIZE  byte count minus one.
REQ-012 wr_data, wr_valid, wr_ready  in/in/out  8/1/1  write byte stream.
REQ-013 rd_data, rd_valid  out/out  8/1  read byte stream; no backpressure.
REQ-014 busy, done, contention  out  1 each  status: burst in progress, one-cycle completion pulse, sticky bus-conflict flag.
REQ-015 usb_addr, usb_dout  out  8/8  address and write data to target.
REQ-016 usb_din  in  8  read data from target.
REQ-017 usb_cen, usb_rdn, usb_wrn  out  1 each  active-low chip enable, read strobe, write strobe.
REQ-018 usb_drive  out  1  host enables its data drivers.
REQ-019 usb_isout  in  1  target is driving the data bus.

Function
REQ-020 FSM states: IDLE, WDATA, SETUP, STROBE, HOLD; one 4-bit phase counter, one pBYTECNT_SIZE-bit remaining-byte counter.
REQ-021 cmd_ready = 1 only in IDLE; busy = not IDLE; cmd_valid ignored otherwise.
REQ-022 On accept: latch cmd_addr to usb_addr, cmd_write, cmd_len to byte counter, clear contention; next state WDATA if write, SETUP if read.
REQ-023 usb_addr constant for the entire burst (target byte counter must not reset mid-burst).
REQ-024 WDATA: wr_ready = 1; on wr_valid capture wr_data into usb_dout, go SETUP; wr_ready = 0 in all other states; exactly one byte consumed per write byte.
REQ-025 SETUP lasts pSETUP cycles, then STROBE; STROBE lasts pSTROBE cycles with usb_wrn (write) or usb_rdn (read) low, then HOLD; HOLD lasts pHOLD cycles.
REQ-026 End of HOLD: byte counter zero -> IDLE; else decrement, go WDATA (write) or SETUP (read).
REQ-027 usb_cen low in every non-IDLE state, including WDATA stalls between bytes.
REQ-028 usb_rdn and usb_wrn never low simultaneously; both high outside STROBE.
REQ-029 usb_drive = 1 in SETUP, STROBE, HOLD of write bursts only; usb_dout unchanged from SETUP through HOLD.
REQ-030 Read: usb_din registered into rd_data at the edge ending the last STROBE cycle; rd_valid high one cycle (first HOLD cycle).
REQ-031 done pulses one cycle, the first IDLE cycle after the final HOLD.
REQ-032 contention set when usb_drive and usb_isout both high on any edge; held until reset or next accept.
REQ-033 cmd_len all-ones yields 2^pBYTECNT_SIZE bytes; byte counter never wraps.

Reset
REQ-034 Reset asserted (any state, mid-strobe included): immediately state IDLE, usb_cen/usb_rdn/usb_wrn = 1, usb_drive = 0, cmd_ready = 1.
REQ-035 Reset values: usb_addr = 0, usb_dout = 0, rd_data = 0, rd_valid = 0, wr_ready = 0, busy = 0, done = 0, contention = 0, counters = 0.

Verification
REQ-036 Defaults, write addr 0x12 len 0, wr_valid held with 0xA5 -> usb_cen low 7 cycles, usb_wrn low 3, usb_dout 0xA5 throughout, done 1 cycle later.
REQ-037 Read addr 0x40 len 3, target returns 0x10,0x11,0x12,0x13 -> four rd_valid pulses in order, usb_addr 0x40 constant, usb_cen low 24 cycles.
REQ-038 Write len 1, wr_valid low 5 cycles before byte 2 -> usb_cen stays low, usb_wrn high during stall, second byte correct.
REQ-039 Reset asserted during second STROBE cycle of a write -> strobes/cen high and usb_drive low same cycle; next command runs normally.
REQ-040 Write burst with usb_isout forced high in HOLD -> contention = 1, persists past done, clears on next accept.
REQ-041 cmd_valid held high through a busy burst -> exactly one extra command accepted, first IDLE cycle after done.
